fpu_lite_responder: RTL and testbench
=====================================

FPU_LITE_RESPONDER -- requirements
Module: fpu_lite_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port ctl, input, 4 bits: operation code, sampled only when en=1.
REQ-004 SHALL have port x1, input, 32 bits: operand 1, IEEE-754 single.
REQ-005 SHALL have port x2, input, 32 bits: operand 2, IEEE-754 single.
REQ-006 SHALL have port en, input, 1 bit: one-cycle request strobe.
REQ-007 SHALL have port y, output, 32 bits: result, valid only while ready=1.
REQ-008 SHALL have port ready, output, 1 bit: one-cycle result strobe.
REQ-009 SHALL have port busy, output, 1 bit: operation in flight, new en ignored.
REQ-010 SHALL have port ovf, output, 1 bit: fmul overflow flag, qualified by ready.
REQ-011 SHALL have port err, output, 1 bit: unsupported ctl flag, qualified by ready.
REQ-012 SHALL have parameter MUL_LAT, default 3: fmul latency in cycles, legal range 2..4.

Function
REQ-013 SHALL support these ctl codes: 4 fmul, 7 fhalf, 11 feq, 12 fle, 13 fabs, 14 fneg.
REQ-014 SHALL handle any other ctl code as unsupported: 1-cycle latency, y=0, err=1.
REQ-015 SHALL use two states, IDLE and MUL: IDLE->MUL on accepted en with ctl=4; MUL->IDLE on the cycle ready is asserted.
REQ-016 SHALL accept a request only when en=1 at a rising edge with busy=0.
REQ-017 SHALL, for a non-fmul request accepted at edge N, register y/ready at edge N, so ready=1 for exactly the one cycle after edge N.
REQ-018 SHALL, for fmul accepted at edge N, raise busy after edge N and assert ready (with busy still 1) for exactly one cycle after edge N+MUL_LAT-1; busy clears at the following edge.
REQ-019 SHALL silently drop en=1 while busy=1, with no state change and no ready.
REQ-020 SHALL latch ctl/x1/x2 at acceptance; later input changes SHALL NOT affect the result.
REQ-021 SHALL drive y=0, ovf=0, err=0 in every cycle where ready=0.
REQ-022 fabs SHALL return x1 with bit31 cleared; fneg SHALL return x1 with bit31 inverted (bit-exact, including zero, inf and NaN).
REQ-023 fhalf SHALL decrement the exponent when exp in 2..254; exp 0 or 1 SHALL give signed zero; exp 255 SHALL return x1 unchanged.
REQ-024 feq/fle SHALL return y={31'b0,b}; +0 and -0 compare equal; any operand with exp=255 and mantissa!=0 SHALL give b=0.
REQ-025 fmul SHALL treat inputs with exp=0 as signed zero; result sign = x1[31]^x2[31].
REQ-026 fmul SHALL form the 48-bit product of the 24-bit significands, normalize by at most 1 bit, and round to nearest even.
REQ-027 fmul SHALL set the biased result exp to e1+e2-127(+1 if normalized, +1 if rounding carries).
REQ-028 fmul SHALL return signed zero, with ovf=0, when the result exp is <=0.
REQ-029 fmul SHALL return signed inf and ovf=1 when the result exp is >=255.
REQ-030 fmul SHALL return signed inf, ovf=0, when an operand has exp=255 and the other is nonzero.
REQ-031 fmul SHALL return 0x7FC00000 for inf*0.

Reset
REQ-032 SHALL, while rstn=0 at a rising edge, force y=0, ready=0, busy=0, ovf=0, err=0, and state IDLE.
REQ-033 SHALL discard any in-flight fmul on reset; no ready SHALL follow for it after reset is released.
REQ-034 SHALL ignore en sampled while rstn=0.

Verification
REQ-035 fmul x1=0x40000000, x2=0x40400000, accepted at edge N -> y=0x40C00000, ready=1 only after edge N+2 (MUL_LAT=3), ovf=0, err=0.
REQ-036 fhalf x1=0x40400000 -> y=0x3FC00000 after edge N; fhalf x1=0x00800000 -> y=0x00000000.
REQ-037 feq x1=0x00000000, x2=0x80000000 -> y=0x00000001; fle x1=0xBF800000, x2=0x3F800000 -> y=0x00000001; fle with the operands swapped -> y=0.
REQ-038 fmul x1=0x7F000000, x2=0x7F000000 -> y=0x7F800000 and ovf=1.
REQ-039 en held 1 for 3 cycles with an fmul first and fabs requests after -> exactly one ready (the fmul); the fabs requests are dropped.
REQ-040 rstn=0 one cycle after an fmul is accepted -> no ready ever appears; next fneg x1=0x3F800000 -> y=0xBF800000 one cycle later; ctl=2 -> y=0, err=1.

Source files
------------

// File: rtl/fpu_lite_responder.sv
// Single-precision helper unit: one-cycle compare/sign/halving ops and a
// MUL_LAT-cycle multiply.
//   state | meaning
//   IDLE  | accepting requests; non-multiply results registered directly
//   MUL   | multiply in flight; busy=1, new requests dropped
module fpu_lite_responder #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  ctl,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        en,
  output logic [31:0] y,
  output logic        ready,
  output logic        busy,
  output logic        ovf,
  output logic        err
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_FMUL  = 4'd4;
  localparam logic [3:0] OP_FHALF = 4'd7;
  localparam logic [3:0] OP_FEQ   = 4'd11;
  localparam logic [3:0] OP_FLE   = 4'd12;
  localparam logic [3:0] OP_FABS  = 4'd13;
  localparam logic [3:0] OP_FNEG  = 4'd14;
  localparam logic [1:0] CNT_LOAD = 2'(MUL_LAT - 2);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] x1_q, x1_d, x2_q, x2_d;
  logic [31:0] y_q, y_d;
  logic        ready_q, ready_d, ovf_q, ovf_d, err_q, err_d;

  logic [7:0]  e1, e2;
  logic        sgn, norm, guard, sticky, rnd_up;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic [9:0]  exp_r;
  logic [31:0] mul_y;
  logic        mul_ovf;

  // Multiply datapath works on the operands latched at acceptance.
  always_comb begin
    e1      = x1_q[30:23];
    e2      = x2_q[30:23];
    sgn     = x1_q[31] ^ x2_q[31];
    prod    = {24'b0, 1'b1, x1_q[22:0]} * {24'b0, 1'b1, x2_q[22:0]};
    norm    = prod[47];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd_up  = guard & (sticky | mant[0]);
    mant_r  = {1'b0, mant} + {23'b0, rnd_up};
    // 10-bit two's complement: range is -125..383, so bit 9 is the sign.
    exp_r   = {2'b0, e1} + {2'b0, e2} + {9'b0, norm} + {9'b0, mant_r[23]} - 10'd127;
    mul_ovf = 1'b0;
    if (((e1 == 8'hFF) && (e2 == 8'h00)) || ((e2 == 8'hFF) && (e1 == 8'h00))) begin
      mul_y = 32'h7FC0_0000;
    end else if ((e1 == 8'hFF) || (e2 == 8'hFF)) begin
      mul_y = {sgn, 8'hFF, 23'b0};
    end else if ((e1 == 8'h00) || (e2 == 8'h00)) begin
      mul_y = {sgn, 31'b0};
    end else if (exp_r[9] || (exp_r == 10'd0)) begin
      mul_y = {sgn, 31'b0};
    end else if (exp_r >= 10'd255) begin
      mul_y   = {sgn, 8'hFF, 23'b0};
      mul_ovf = 1'b1;
    end else begin
      mul_y = {sgn, exp_r[7:0], mant_r[22:0]};
    end
  end

  logic        nan1, nan2, both_zero, eq_b, le_b;
  logic [31:0] op_y;
  logic        op_err;

  always_comb begin
    nan1      = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'b0);
    nan2      = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'b0);
    both_zero = (x1[30:0] == 31'b0) && (x2[30:0] == 31'b0);
    eq_b      = !nan1 && !nan2 && (both_zero || (x1 == x2));
    le_b      = !nan1 && !nan2 &&
                (both_zero ||
                 (x1[31] && !x2[31]) ||
                 (!x1[31] && !x2[31] && (x1[30:0] <= x2[30:0])) ||
                 (x1[31] && x2[31] && (x1[30:0] >= x2[30:0])));
    op_y   = 32'b0;
    op_err = 1'b0;
    case (ctl)
      OP_FHALF: begin
        if (x1[30:23] == 8'hFF)       op_y = x1;
        else if (x1[30:24] == 7'b0)   op_y = {x1[31], 31'b0};
        else                          op_y = {x1[31], x1[30:23] - 8'd1, x1[22:0]};
      end
      OP_FEQ:  op_y = {31'b0, eq_b};
      OP_FLE:  op_y = {31'b0, le_b};
      OP_FABS: op_y = {1'b0, x1[30:0]};
      OP_FNEG: op_y = {~x1[31], x1[30:0]};
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y_d     = 32'b0;
    ready_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (ctl == OP_FMUL) begin
            state_d = MUL;
            cnt_d   = CNT_LOAD;
            x1_d    = x1;
            x2_d    = x2;
          end else begin
            y_d     = op_y;
            err_d   = op_err;
            ready_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (ready_q) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          y_d     = mul_y;
          ovf_d   = mul_ovf;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      x1_q    <= 32'b0;
      x2_q    <= 32'b0;
      y_q     <= 32'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign ready = ready_q;
  assign ovf   = ovf_q;
  assign err   = err_q;
  assign busy  = (state_q == MUL);

endmodule

// File: tb/tb_fpu_lite_responder.sv
// Directed bench for fpu_lite_responder: vector table plus multi-cycle sequences.
module tb_fpu_lite_responder;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  ctl;
  logic [31:0] x1, x2;
  logic        en;
  logic [31:0] y;
  logic        ready, busy, ovf, err;

  int n_pass = 0;
  int n_total = 0;

  fpu_lite_responder #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rstn(rstn), .ctl(ctl), .x1(x1), .x2(x2), .en(en),
    .y(y), .ready(ready), .busy(busy), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ey;
    logic        eovf;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey,
                        input logic eovf, input logic eerr);
    int lat;
    @(negedge clk);
    ctl = c; x1 = a; x2 = b; en = 1'b1;
    tick;
    en = 1'b0;
    x1 = ~a; x2 = ~b; ctl = 4'd13;
    lat = 1;
    while (!ready && lat < 8) begin
      tick;
      lat++;
    end
    chk({nm, " latency"}, lat, (c == 4'd4) ? MUL_LAT : 1);
    chk({nm, " y"}, y, ey);
    chk({nm, " ovf/err/busy"}, {ovf, err, busy}, {eovf, eerr, (c == 4'd4)});
    tick;
    chk({nm, " after"}, {y, ready, busy, ovf, err}, 36'b0);
  endtask

  initial begin
    int nrdy, rdy_at;
    logic [31:0] rdy_y;

    vecs.push_back('{4'd4,  32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  32'h4040_0000, 32'h0,         32'h3FC0_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  32'h0080_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  32'h8080_0000, 32'h0,         32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  32'h7F80_0001, 32'h0,         32'h7F80_0001, 1'b0, 1'b0});
    vecs.push_back('{4'd11, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'd11, 32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd12, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'd12, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd12, 32'hC000_0000, 32'hBF80_0000, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'd13, 32'hFF80_0000, 32'h0,         32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd14, 32'h0000_0000, 32'h0,         32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0});
    vecs.push_back('{4'd4,  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'h8040_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'h3F80_0800, 32'h3F80_0800, 32'h3F80_1000, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd2,  32'h1234_5678, 32'h0,         32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{4'd15, 32'h3F80_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b1});

    // Reset with a request pending: nothing may come out.
    rstn = 1'b0; en = 1'b1; ctl = 4'd13; x1 = 32'hBF80_0000; x2 = 32'h0;
    tick; tick; tick;
    chk("reset outputs", {y, ready, busy, ovf, err}, 36'b0);
    @(negedge clk);
    rstn = 1'b1; en = 1'b0;
    tick;
    chk("reset en ignored", {y, ready, busy}, 34'b0);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b,
             vecs[i].ey, vecs[i].eovf, vecs[i].eerr);

    // en held for three edges: fmul then two fabs that must be dropped.
    @(negedge clk);
    ctl = 4'd4; x1 = 32'h4000_0000; x2 = 32'h4040_0000; en = 1'b1;
    nrdy = 0; rdy_at = -1; rdy_y = 32'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) begin
        chk("hold busy", busy, 1'b1);
        ctl = 4'd13; x1 = 32'hBF80_0000; x2 = 32'h0;
      end
      if (i == 2) en = 1'b0;
      if (ready) begin
        nrdy++;
        rdy_at = i;
        rdy_y = y;
      end
    end
    chk("hold ready count", nrdy, 1);
    chk("hold ready edge", rdy_at, MUL_LAT - 1);
    chk("hold y", rdy_y, 32'h40C0_0000);
    chk("hold idle", busy, 1'b0);

    // Reset one cycle after accepting a multiply.
    @(negedge clk);
    ctl = 4'd4; x1 = 32'h4000_0000; x2 = 32'h4040_0000; en = 1'b1;
    tick;
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    tick;
    chk("abort state", {ready, busy}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (ready) nrdy++;
    end
    chk("abort no ready", nrdy, 0);
    run_op("post fneg", 4'd14, 32'h3F80_0000, 32'h0, 32'hBF80_0000, 1'b0, 1'b0);
    run_op("post bad", 4'd2, 32'h3F80_0000, 32'h0, 32'h0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
